inverse_zigzag_4x4: RTL and testbench

- Inverse of the zigzag scan stage. Accepts 4x4 residual coefficients serially in zigzag order and re-emits each block in raster order (row-major, index = 4*row + col).
- Used on the decode/verification path, feeding reconstruction or the reference comparator.
- Ping-pong storage: one bank fills while the other drains, so sustained throughput is 1 coefficient/cycle on each side.

---
 rtl/cavlc_pkg.sv | 13 +
 rtl/inverse_zigzag_4x4_if.sv | 25 ++
 rtl/ivz_beat_counter.sv | 21 ++
 rtl/inverse_zigzag_4x4.sv | 84 ++++++++
 tb/tb_inverse_zigzag_4x4.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC residual path: zigzag scan table and block geometry.
package cavlc_pkg;
    localparam int unsigned BLK_SIZE       = 16;
    localparam int unsigned COEF_W_DEFAULT = 16;

    typedef logic [3:0] idx_t;

    // Zigzag position k -> raster index (4*row + col) within a 4x4 block.
    localparam idx_t ZZ4X4 [BLK_SIZE] = '{
        4'd0,  4'd1,  4'd4,  4'd8,  4'd5,  4'd2,  4'd3,  4'd6,
        4'd9,  4'd12, 4'd13, 4'd10, 4'd7,  4'd11, 4'd14, 4'd15
    };
endpackage

// File: rtl/inverse_zigzag_4x4_if.sv
// Streaming handshake bundle for the inverse zigzag stage: zigzag-order input, raster-order output.
interface inverse_zigzag_4x4_if
    import cavlc_pkg::*;
#(
    parameter int unsigned COEF_W = COEF_W_DEFAULT
);
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              out_valid;
    logic              out_ready;
    logic [COEF_W-1:0] out_coef;
    logic [3:0]        out_idx;
    logic              out_last;

    modport master (
        output in_valid, in_coef, out_ready,
        input  in_ready, out_valid, out_coef, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_coef, out_ready,
        output in_ready, out_valid, out_coef, out_idx, out_last
    );
endinterface

// File: rtl/ivz_beat_counter.sv
// 4-bit wrapping beat counter with synchronous clear; wrap pulses on the enabled 16th beat.
module ivz_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] count,
    output logic       wrap
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign wrap = en & (count == 4'd15);
endmodule

// File: rtl/inverse_zigzag_4x4.sv
// Inverse zigzag for 4x4 blocks: ping-pong banks, one filling in zigzag order while the other drains in raster order.
module inverse_zigzag_4x4
    import cavlc_pkg::*;
#(
    parameter int unsigned COEF_W = COEF_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    inverse_zigzag_4x4_if.slave  bus
);
    logic [3:0]        wr_cnt;
    logic [3:0]        rd_cnt;
    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        bank_full;
    logic              wr_en;
    logic              rd_en;
    logic              wr_wrap;
    logic              rd_wrap;
    logic [COEF_W-1:0] mem [2][BLK_SIZE];

    assign bus.in_ready  = !bank_full[wr_bank];
    assign bus.out_valid = bank_full[rd_bank];
    assign bus.out_idx   = rd_cnt;
    assign bus.out_coef  = bus.out_valid ? mem[rd_bank][rd_cnt] : '0;
    assign bus.out_last  = bus.out_valid & (rd_cnt == 4'd15);

    // A flush discards any beat presented alongside it on either side.
    assign wr_en = bus.in_valid & bus.in_ready & !clr;
    assign rd_en = bus.out_valid & bus.out_ready & !clr;

    ivz_beat_counter u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (wr_en),
        .count (wr_cnt),
        .wrap  (wr_wrap)
    );

    ivz_beat_counter u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (rd_en),
        .count (rd_cnt),
        .wrap  (rd_wrap)
    );

    // Set and clear of bank_full in the same cycle always hit different banks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= '0;
        end else if (clr) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= '0;
        end else begin
            if (wr_wrap) begin
                bank_full[wr_bank] <= 1'b1;
                wr_bank            <= ~wr_bank;
            end
            if (rd_wrap) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < BLK_SIZE; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[wr_bank][ZZ4X4[wr_cnt]] <= bus.in_coef;
        end
    end
endmodule

// File: tb/tb_inverse_zigzag_4x4.sv
// Bench for inverse_zigzag_4x4: block-level reorder model checked every cycle plus directed literal pins.
module tb_inverse_zigzag_4x4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;

    inverse_zigzag_4x4_if #(.COEF_W(16)) bus ();

    inverse_zigzag_4x4 #(.COEF_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int          zz [16];
    logic [15:0] lit [16];
    logic [15:0] exp_q [$];
    logic [15:0] part [16];
    logic [15:0] cap_q [$];
    int          part_cnt = 0;
    int          rd_pos = 0;
    int          nb;
    int          acc_total = 0;
    int          xfer_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a block is complete after 16 accepts; completed blocks queue up in raster order.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            part_cnt = 0;
            rd_pos   = 0;
        end else begin
            nb = (exp_q.size() + 15) / 16;
            chk("in_ready", bus.in_ready, nb < 2);
            chk("out_valid", bus.out_valid, nb > 0);
            if (nb > 0) begin
                chk("out_coef", bus.out_coef, exp_q[0]);
                chk("out_idx", bus.out_idx, rd_pos);
                chk("out_last", bus.out_last, rd_pos == 15);
            end else begin
                chk("idle_coef", bus.out_coef, 0);
                chk("idle_idx", bus.out_idx, 0);
                chk("idle_last", bus.out_last, 0);
            end
            if (clr) begin
                exp_q.delete();
                part_cnt = 0;
                rd_pos   = 0;
            end else begin
                if (nb > 0 && bus.out_ready) begin
                    cap_q.push_back(bus.out_coef);
                    void'(exp_q.pop_front());
                    rd_pos = (rd_pos + 1) % 16;
                    xfer_total++;
                end
                if (bus.in_valid && nb < 2) begin
                    part[zz[part_cnt]] = bus.in_coef;
                    part_cnt++;
                    acc_total++;
                    if (part_cnt == 16) begin
                        for (int i = 0; i < 16; i++) exp_q.push_back(part[i]);
                        part_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int c0;
        int a0;
        int x0;
        int gaps;
        int stalls;
        int coef;

        // Zigzag walks anti-diagonals; odd diagonals go down the rows, even ones go up.
        n = 0;
        for (int s = 0; s < 7; s++) begin
            for (int i = 0; i < 4; i++) begin
                int r;
                int c;
                r = (s % 2 == 1) ? i : 3 - i;
                c = s - r;
                if (c >= 0 && c <= 3) begin
                    zz[n] = 4 * r + c;
                    n++;
                end
            end
        end
        lit = '{16'd100, 16'd101, 16'd105, 16'd106, 16'd102, 16'd104, 16'd107, 16'd112,
                16'd103, 16'd108, 16'd111, 16'd113, 16'd109, 16'd110, 16'd114, 16'd115};

        bus.in_valid  = 1'b0;
        bus.in_coef   = '0;
        bus.out_ready = 1'b0;
        #22;
        rst = 1'b1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_coef", bus.out_coef, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_last", bus.out_last, 0);
        step();

        // Single block 100+k.
        c0 = cap_q.size();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.in_valid = 1'b1;
            bus.in_coef  = 16'(100 + k);
            chk("pre_valid", bus.out_valid, 0);
            step();
        end
        bus.in_valid = 1'b0;
        chk("first_valid", bus.out_valid, 1);
        chk("first_coef", bus.out_coef, 100);
        for (int i = 0; i < 40 && cap_q.size() < c0 + 16; i++) step();
        chk("blk1_count", cap_q.size() - c0, 16);
        for (int k = 0; k < 16 && c0 + k < cap_q.size(); k++) chk("blk1_seq", cap_q[c0 + k], lit[k]);

        // Three blocks back to back.
        x0 = xfer_total;
        gaps = 0;
        stalls = 0;
        for (int i = 0; i < 48; i++) begin
            bus.in_valid = 1'b1;
            bus.in_coef  = 16'(1000 + i);
            if (!bus.in_ready) stalls++;
            if (xfer_total > x0 && xfer_total < x0 + 48 && !bus.out_valid) gaps++;
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 100 && xfer_total < x0 + 48; i++) begin
            if (xfer_total > x0 && xfer_total < x0 + 48 && !bus.out_valid) gaps++;
            step();
        end
        chk("b2b_stalls", stalls, 0);
        chk("b2b_gaps", gaps, 0);
        chk("b2b_xfers", xfer_total - x0, 48);

        // Output stalled: both banks fill, third block waits.
        a0 = acc_total;
        coef = 2000;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = 1'b1;
            bus.in_coef  = 16'(coef);
            coef++;
            step();
            if (!bus.in_ready) break;
        end
        chk("full_accepts", acc_total - a0, 32);
        chk("full_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && acc_total < a0 + 48; i++) begin
            bus.in_coef = 16'(coef);
            coef++;
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) step();
        chk("full_drained", exp_q.size(), 0);
        chk("full_total", acc_total - a0, 48);

        // Flush after a partial block.
        for (int k = 0; k < 7; k++) begin
            bus.in_valid = 1'b1;
            bus.in_coef  = 16'(900 + k);
            step();
        end
        clr = 1'b1;
        bus.in_coef = 16'hdead;
        step();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_in_ready", bus.in_ready, 1);
        chk("clr_out_valid", bus.out_valid, 0);
        c0 = cap_q.size();
        for (int k = 0; k < 16; k++) begin
            bus.in_valid = 1'b1;
            bus.in_coef  = 16'(300 + k);
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40 && cap_q.size() < c0 + 16; i++) step();
        chk("clr_count", cap_q.size() - c0, 16);
        for (int k = 0; k < 16 && c0 + k < cap_q.size(); k++) chk("clr_seq", cap_q[c0 + k], lit[k] + 16'd200);

        // Asynchronous reset in the middle of a drain.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.in_valid = 1'b1;
            bus.in_coef  = 16'(500 + k);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && rd_pos != 5; i++) step();
        bus.out_ready = 1'b0;
        chk("mid_idx", bus.out_idx, 5);
        chk("mid_valid", bus.out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_coef", bus.out_coef, 0);
        chk("arst_out_idx", bus.out_idx, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        step();
        c0 = cap_q.size();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.in_valid = 1'b1;
            bus.in_coef  = 16'(700 + k);
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 40 && cap_q.size() < c0 + 16; i++) step();
        chk("post_rst_count", cap_q.size() - c0, 16);
        for (int k = 0; k < 16 && c0 + k < cap_q.size(); k++) chk("post_rst_seq", cap_q[c0 + k], lit[k] + 16'd600);

        // Random stalls on both sides over 200 blocks.
        a0 = acc_total;
        for (int i = 0; i < 20000 && acc_total < a0 + 3200; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_coef   = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
        chk("rand_accepts", acc_total - a0, 3200);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_partial", part_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
